// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and receiver/transmitter state encoding.
package uart_pkg;

  // 9600 baud from a 100 MHz clock.
  localparam int unsigned CLKS_PER_BIT_DEF = 10416;
  localparam int unsigned HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a one-entry output register and
// ready/ack handshake, framing-error and sticky overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_100,
  input  logic       clr_n,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       led_rx
);

  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF_BIT - 1);

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk_100),
    .rst_n (clr_n),
    .d     (rx),
    .q     (rx_s)
  );

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk_100 or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: frame FSM plus the consumer handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Ack only counts while a byte is pending; overrun implies ready, so it clears too.
    if (ack && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            data_d  = shift_q;
            ferr_d  = 1'b0;
            // A new byte overrides a same-cycle ack; without ack it overwrites.
            if (ready_q && !ack) begin
              ovr_d = 1'b1;
            end
            ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign led_rx    = (state_q != StIdle);

endmodule
